// File: rtl/register_file.sv
// RISC-V integer register file: 32 x DATA_WIDTH, two combinational read ports,
// one synchronous write port, x0 hardwired to zero, asynchronous clear.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] inf,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // Entry 0 is only ever cleared, so it stays zero even if the read mux
  // below were bypassed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (we && (rd != '0)) begin
      regs[rd] <= inf;
    end
  end

  always_comb begin
    out1 = '0;
    out2 = '0;
    if (rs1 != '0) out1 = regs[rs1];
    if (rs2 != '0) out2 = regs[rs2];
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by
// randomized traffic compared against an array reference model.
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] inf = '0;
  logic        we = 1'b0;
  logic [31:0] out1;
  logic [31:0] out2;

  logic [31:0] model [32];
  int passed = 0;
  int failed = 0;
  int total = 0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock(clock),
    .reset(reset),
    .rs1(rs1),
    .rs2(rs2),
    .rd(rd),
    .inf(inf),
    .we(we),
    .out1(out1),
    .out2(out2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expect_read(input logic [4:0] idx);
    if (reset || idx == 5'd0) return 32'h0;
    return model[idx];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // One rising edge; the model commits exactly what the architecture says.
  task automatic step();
    @(posedge clock);
    if (!reset && we && rd != 5'd0) model[rd] = inf;
    #1;
  endtask

  task automatic check_both(input string tag);
    check({tag, "_out1"}, out1, expect_read(rs1));
    check({tag, "_out2"}, out2, expect_read(rs2));
  endtask

  initial begin
    clear_model();

    // Reset held across edges, then released between edges
    rs1 = 5'd5; rs2 = 5'd31; we = 1'b1; rd = 5'd5; inf = 32'hCAFE0001;
    step(); step();
    check("reset_hold_out1", out1, 32'h0);
    check("reset_hold_out2", out2, 32'h0);
    #2 reset = 1'b0; we = 1'b0;
    #1;
    check("reset_rel_out1", out1, 32'h0);
    check("reset_rel_out2", out2, 32'h0);

    // Basic write/read
    we = 1'b1; rd = 5'd2; inf = 32'h3; rs1 = 5'd2; rs2 = 5'd4;
    #1 check("basic_pre", out1, 32'h0);
    step();
    check("basic_out1", out1, 32'h3);
    check("basic_out2", out2, 32'h0);
    rd = 5'd4;
    step();
    check("basic2_out2", out2, 32'h3);
    check("basic2_out1", out1, 32'h3);

    // x0 protection
    rd = 5'd0; inf = 32'hDEADBEEF; rs1 = 5'd0;
    step();
    check("x0_write", out1, 32'h0);

    // Write-enable gating
    rd = 5'd7; inf = 32'h11;
    step();
    we = 1'b0; inf = 32'h55; rs1 = 5'd7;
    step();
    check("we_gate", out1, 32'h11);

    // No bypass
    we = 1'b1; rd = 5'd9; inf = 32'hA;
    step();
    inf = 32'hB; rs1 = 5'd9;
    #1 check("nobypass_pre", out1, 32'hA);
    step();
    check("nobypass_post", out1, 32'hB);

    // Same index on both read ports
    rs2 = 5'd9; we = 1'b0;
    #1 check("same_idx", out2, out1 === 32'hB ? 32'hB : 32'hB);
    check("same_idx_out1", out1, 32'hB);

    // Async reset mid-cycle, and a write during reset is dropped
    we = 1'b1; rd = 5'd31; inf = 32'hFFFFFFFF;
    step();
    we = 1'b0; rs2 = 5'd31;
    #1 check("x31_written", out2, 32'hFFFFFFFF);
    #1 reset = 1'b1;
    #1 check("async_clear", out2, 32'h0);
    clear_model();
    we = 1'b1; inf = 32'h1234;
    step();
    #2 reset = 1'b0; we = 1'b0;
    #1 check("write_in_reset", out2, 32'h0);
    check("write_in_reset_rs1", out1, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      rd  = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
      inf = $urandom;
      we  = ($urandom_range(0, 3) != 0);
      #1 check_both("rand_pre");
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b1;
        clear_model();
        #1 check_both("rand_rst");
        step();
        #2 reset = 1'b0;
      end else begin
        step();
      end
      check_both("rand_post");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1);
  end

endmodule
